// File: rtl/kb_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// kb_scan_ctrl_pkg
// Shared constants for the 4x4 keypad scan/debounce controller.
//   - Default geometry and timing (rows, columns, scan divider, debounce frames)
//   - rd_data flag bit positions for the default 32-bit IO data width
//   - Debounce FSM state encodings and the frame-result kind
// Optional build macro used by this block: KB_FIFO_EN (4-entry event FIFO).
// ----------------------------------------------------------------------------
package kb_scan_ctrl_pkg;

   localparam int KB_ROWS            = 4;
   localparam int KB_COLS            = 4;
   localparam int KB_SCAN_DIV        = 1000;
   localparam int KB_DEBOUNCE_FRAMES = 4;
   localparam int KB_DATA_W          = 32;

   // Flag positions within a KB_DATA_W-wide status word.
   localparam int KB_BIT_VALID = KB_DATA_W - 1;
   localparam int KB_BIT_OVF   = KB_DATA_W - 2;
   localparam int KB_BIT_HELD  = KB_DATA_W - 3;

   // Debounce FSM state encodings.
   localparam logic [1:0] KB_IDLE     = 2'd0;
   localparam logic [1:0] KB_PRESS_DB = 2'd1;
   localparam logic [1:0] KB_HELD     = 2'd2;
   localparam logic [1:0] KB_REL_DB   = 2'd3;

   // Outcome of one complete scan frame.
   typedef enum logic [1:0] {
      KB_FR_NONE   = 2'd0,
      KB_FR_SINGLE = 2'd1,
      KB_FR_MULTI  = 2'd2
   } kb_frame_t;

endpackage

// File: rtl/kb_event_fifo.sv
// ----------------------------------------------------------------------------
// kb_event_fifo
// Key-event queue behind the keypad status word, with sticky overflow.
// Build macro: KB_FIFO_EN
//   defined   : 4-entry circular FIFO (2-bit pointers plus an entry count)
//   undefined : single holding register plus valid bit
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr, wr_code     push strobe and key code
//   pop             read strobe; pops when non-empty, always clears overflow
//   head            oldest code, 0 when empty
//   not_empty       queue holds at least one entry
//   overflow        sticky: a push was dropped because the queue was full
// A pop and a push on the same cycle are ordered pop-first, so a push into a
// full queue that is being read is accepted without raising overflow.
// ----------------------------------------------------------------------------
module kb_event_fifo #(
   parameter int CODE_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [CODE_W-1:0] wr_code,
   input  logic              pop,
   output logic [CODE_W-1:0] head,
   output logic              not_empty,
   output logic              overflow
);

   logic full;
   logic do_pop;
   logic accept;
   logic ovf_reg;

   assign do_pop = pop & not_empty;
   assign accept = wr & (~full | do_pop);

`ifdef KB_FIFO_EN
   logic [CODE_W-1:0] mem [4];
   logic [1:0]        wr_ptr_reg;
   logic [1:0]        rd_ptr_reg;
   logic [2:0]        count_reg;

   assign not_empty = (count_reg != 3'd0);
   assign full      = (count_reg == 3'd4);
   assign head      = not_empty ? mem[rd_ptr_reg] : '0;

   // Storage needs no reset: the head is masked whenever the count is zero.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr_reg] <= wr_code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= 2'd0;
         rd_ptr_reg <= 2'd0;
         count_reg  <= 3'd0;
      end else begin
         if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + 2'd1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 2'd1;
         end
         case ({accept, do_pop})
            2'b10:   count_reg <= count_reg + 3'd1;
            2'b01:   count_reg <= count_reg - 3'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end
`else
   logic [CODE_W-1:0] hold_reg;
   logic              valid_reg;

   assign not_empty = valid_reg;
   assign full      = valid_reg;
   assign head      = valid_reg ? hold_reg : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_reg  <= '0;
         valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            hold_reg  <= wr_code;
            valid_reg <= 1'b1;
         end else if (do_pop) begin
            valid_reg <= 1'b0;
         end
      end
   end
`endif

   // Any read clears overflow; a dropped push on the same edge re-arms it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_reg <= 1'b0;
      end else begin
         if (wr && !accept) begin
            ovf_reg <= 1'b1;
         end else if (pop) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   assign overflow = ovf_reg;

endmodule

// File: rtl/kb_scan_ctrl.sv
// ----------------------------------------------------------------------------
// kb_scan_ctrl
// Keypad matrix scanner with frame-based debounce and a CPU-readable event
// queue on the IO bus.
// Build macro: KB_FIFO_EN (selects the 4-entry queue in kb_event_fifo).
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   col_in   column lines, active-low (0 = key closed on the driven row)
//   row_en   row strobes, active-low, at most one bit low
//   rd_req   one-cycle read-and-pop strobe from the IO decoder
//   rd_data  {valid, overflow, held, 0..., head code}, combinational
//   key_irq  high while the event queue is non-empty
// ----------------------------------------------------------------------------
module kb_scan_ctrl
   import kb_scan_ctrl_pkg::*;
#(
   parameter int ROWS            = KB_ROWS,
   parameter int COLS            = KB_COLS,
   parameter int SCAN_DIV        = KB_SCAN_DIV,
   parameter int DEBOUNCE_FRAMES = KB_DEBOUNCE_FRAMES,
   parameter int DATA_W          = KB_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [COLS-1:0]   col_in,
   output logic [ROWS-1:0]   row_en,
   input  logic              rd_req,
   output logic [DATA_W-1:0] rd_data,
   output logic              key_irq
);

   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int CODE_W = ROW_W + COL_W;
   localparam int DIV_W  = $clog2(SCAN_DIV);
   localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);

   // Package positions are for the default width; keep them MSB-relative.
   localparam int BIT_VALID = KB_BIT_VALID + DATA_W - KB_DATA_W;
   localparam int BIT_OVF   = KB_BIT_OVF   + DATA_W - KB_DATA_W;
   localparam int BIT_HELD  = KB_BIT_HELD  + DATA_W - KB_DATA_W;

   // ---------------- row sequencer ----------------
   logic              started_reg;
   logic [DIV_W-1:0]  div_reg;
   logic [ROW_W-1:0]  row_reg;
   logic              sample;
   logic              frame_done;

   // started_reg holds all rows high until the first edge after reset.
   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_en
         assign row_en[gi] = ~(started_reg && (row_reg == ROW_W'(gi)));
      end
   endgenerate

   assign sample     = started_reg && (div_reg == DIV_W'(SCAN_DIV - 1));
   assign frame_done = sample && (row_reg == ROW_W'(ROWS - 1));

   // ---------------- frame evaluator ----------------
   logic [1:0]        acc_hits_reg;   // zeros seen so far this frame, saturates at 2
   logic [CODE_W-1:0] acc_code_reg;
   logic [1:0]        row_hits;
   logic [COL_W-1:0]  hit_col;
   logic [2:0]        hit_sum;
   logic [1:0]        frame_hits;
   logic [CODE_W-1:0] frame_code;
   kb_frame_t         frame_kind;

   always_comb begin
      row_hits = 2'd0;
      hit_col  = '0;
      for (int c = 0; c < COLS; c++) begin
         if (!col_in[c]) begin
            if (row_hits != 2'd2) begin
               row_hits = row_hits + 2'd1;
            end
            hit_col = COL_W'(c);
         end
      end
      hit_sum    = {1'b0, acc_hits_reg} + {1'b0, row_hits};
      frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      // If an earlier row already had the single hit, its code wins; a second
      // hit makes the frame MULTI, so the code no longer matters.
      frame_code = (acc_hits_reg != 2'd0) ? acc_code_reg : {row_reg, hit_col};
      frame_kind = KB_FR_NONE;
      if (frame_hits == 2'd1) begin
         frame_kind = KB_FR_SINGLE;
      end else if (frame_hits == 2'd2) begin
         frame_kind = KB_FR_MULTI;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started_reg  <= 1'b0;
         div_reg      <= '0;
         row_reg      <= '0;
         acc_hits_reg <= 2'd0;
         acc_code_reg <= '0;
      end else begin
         started_reg <= 1'b1;
         if (sample) begin
            div_reg      <= '0;
            row_reg      <= frame_done ? '0 : row_reg + ROW_W'(1);
            acc_hits_reg <= frame_done ? 2'd0 : frame_hits;
            acc_code_reg <= frame_done ? '0 : frame_code;
         end else if (started_reg) begin
            div_reg <= div_reg + DIV_W'(1);
         end
      end
   end

   // ---------------- debounce FSM ----------------
   logic [1:0]        state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [CODE_W-1:0] cand_reg;
   logic              enq_reg;
   logic              match;
   logic              last_frame;

   assign match      = (frame_kind == KB_FR_SINGLE) && (frame_code == cand_reg);
   assign last_frame = ((cnt_reg + CNT_W'(1)) == CNT_W'(DEBOUNCE_FRAMES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= KB_IDLE;
         cnt_reg   <= '0;
         cand_reg  <= '0;
         enq_reg   <= 1'b0;
      end else begin
         enq_reg <= 1'b0;
         if (frame_done) begin
            case (state_reg)
               KB_IDLE: begin
                  if (frame_kind == KB_FR_SINGLE) begin
                     cand_reg <= frame_code;
                     if (DEBOUNCE_FRAMES == 1) begin
                        enq_reg   <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= KB_HELD;
                     end else begin
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= KB_PRESS_DB;
                     end
                  end
               end
               KB_PRESS_DB: begin
                  if (match) begin
                     if (last_frame) begin
                        enq_reg   <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= KB_HELD;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                     end
                  end else begin
                     cnt_reg   <= '0;
                     state_reg <= KB_IDLE;
                  end
               end
               KB_HELD: begin
                  if (!match) begin
                     if (DEBOUNCE_FRAMES == 1) begin
                        cnt_reg   <= '0;
                        state_reg <= KB_IDLE;
                     end else begin
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= KB_REL_DB;
                     end
                  end
               end
               KB_REL_DB: begin
                  if (match) begin
                     cnt_reg   <= '0;
                     state_reg <= KB_HELD;
                  end else if (last_frame) begin
                     cnt_reg   <= '0;
                     state_reg <= KB_IDLE;
                  end else begin
                     cnt_reg <= cnt_reg + CNT_W'(1);
                  end
               end
               default: begin
                  cnt_reg   <= '0;
                  state_reg <= KB_IDLE;
               end
            endcase
         end
      end
   end

   // ---------------- event queue and status word ----------------
   // The push is registered, so a confirmed press shows up one cycle after
   // the frame edge. cand_reg only changes on frame edges, so it is stable.
   logic [CODE_W-1:0] head;
   logic              not_empty;
   logic              overflow;

   kb_event_fifo #(
      .CODE_W (CODE_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (enq_reg),
      .wr_code   (cand_reg),
      .pop       (rd_req),
      .head      (head),
      .not_empty (not_empty),
      .overflow  (overflow)
   );

   always_comb begin
      rd_data                = '0;
      rd_data[BIT_VALID]     = not_empty;
      rd_data[BIT_OVF]       = overflow;
      rd_data[BIT_HELD]      = (state_reg == KB_HELD) || (state_reg == KB_REL_DB);
      rd_data[CODE_W-1:0]    = head;
   end

   assign key_irq = not_empty;

endmodule
